relu_quant: RTL and testbench
=============================

Name: relu_quant

Overview:
- Post-accumulation stage directly upstream of the max-pool stage.
- Takes DN lanes of signed convolution accumulator sums per beat, then per lane: adds bias, applies optional ReLU, rounding right-shift, and saturation to DW-bit signed.
- Emits beats on the same DN*DW-wide m/s data bus convention the pooling stage consumes, with an end-of-row marker from a pixel counter.
- 2-stage pipeline with valid/ready backpressure.

Parameters:
DN, 6, lanes per beat
DW, 8, output lane width (signed)
AW, 24, input accumulator lane width (signed)
BW, 16, bias lane width (signed)

Ports:
clk  input  1  clock
rst  input  1  reset
m_data  input  DN*AW  accumulator lanes; lane i at [i*AW +: AW]
m_valid  input  1  input beat valid
m_ready  output  1  input beat accepted when m_valid&&m_ready
cfg_bias  input  DN*BW  per-lane bias; lane i at [i*BW +: BW]
cfg_shift  input  5  right-shift amount, 0..AW-1
cfg_relu_en  input  1  1 = clamp negatives to 0
cfg_width  input  6  pixels (beats) per row, 1..63; 0 treated as 64
s_data  output  DN*DW  quantised lanes
s_valid  output  1  output beat valid
s_ready  input  1  downstream accept
s_eol  output  1  qualifies s_valid: last beat of a row
busy  output  1  any pipeline stage holds a beat

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: s_valid=0, s_data=0, s_eol=0, busy=0, stage valids 0, pixel counter 0. m_ready=1 out of reset.
- Reset mid-stream: all in-flight beats are dropped; s_valid=0 the cycle after rst is sampled high.
- Stage 1 (on accept): per lane, sum1 = sext(m_data_i, AW+1) + sext(cfg_bias_i, AW+1). No overflow is possible.
- Stage 2, per lane:
  - r = sum1 + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0), computed at AW+2 bits.
  - q = r >>> cfg_shift (arithmetic; round half up).
  - If cfg_relu_en and q<0: q=0.
  - Saturate q to [-2^(DW-1), 2^(DW-1)-1].
  - Result registered into s_data.
- Handshake:
  - Stage k advances when it is empty or its downstream slot is consumed: adv2 = !v2 || s_ready; adv1 = !v1 || adv2; m_ready = adv1.
  - s_data and s_valid hold stable while s_valid && !s_ready.
  - The pipeline carries no bubbles: with s_ready=1, one beat per cycle throughput and 2-cycle latency from accept to s_valid.
  - Up to 2 beats are buffered while s_ready=0. m_ready falls combinationally once both stages are full and s_ready=0.
- Pixel counter:
  - Counts beats that leave the output (s_valid && s_ready).
  - s_eol=1 when the beat at the output is number cfg_width of the row (counter == cfg_width-1).
  - The counter wraps to 0 on the eol transfer.
  - The counter value is carried with the beat, so s_eol is stable under stall.
- Config rules:
  - cfg_* are sampled in stage 1 (bias) and stage 2 (shift, relu) at advance time.
  - Software changes cfg_* only while busy=0.
  - A cfg_width change while busy=0 restarts the counter at 0.
- busy = v1 || v2.
- Simultaneous accept and output transfer in the same cycle with both stages full: legal, no loss, order preserved.

Optional Feature:
- Macro RELU_QUANT_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt (16 bits).
  - Increments once per output transfer in which any lane saturated (clip high or clip low; ReLU clamping is not saturation).
  - Sticks at 16'hFFFF; reset to 0 by rst.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Passthrough: bias=0, shift=0, relu=0, s_ready=1, all lanes 24'h000005 -> s_data=48'h050505050505, s_valid 2 cycles after accept.
- Rounding: shift=4, lanes 24 -> 8'h02 and lanes 23 -> 8'h01; bias=8, shift=4, lanes 8 -> 8'h01.
- ReLU and saturation:
  - relu=0: lanes -100 -> 8'h9C; -300 -> 8'h80; 300 -> 8'h7F.
  - relu=1: -100 -> 8'h00; 300 -> 8'h7F.
- Backpressure: stream beats 1..5 with s_ready=0 for cycles 2-5 -> m_ready=0 once 2 beats are held; outputs 1..5 arrive in order with none lost or duplicated; s_data stable while stalled.
- Row marker and reset:
  - cfg_width=2, 6 beats -> s_eol on output beats 2, 4 and 6.
  - Assert rst with 2 beats in flight -> s_valid=0 next cycle, busy=0; next beat after release gets s_eol=0.
- Macro on: 3 beats with lane0=300 and 1 beat clean -> sat_cnt=3; rst -> sat_cnt=0.

Source files
------------

// File: rtl/relu_quant.sv
// Post-accumulation stage: per-lane bias add, round-half-up shift, optional ReLU, DW-bit saturation.
// Optional saturation event counter enabled by defining RELU_QUANT_SAT_CNT_EN.
module relu_quant #(
   parameter int DN = 6,
   parameter int DW = 8,
   parameter int AW = 24,
   parameter int BW = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DN*AW-1:0]   m_data,
   input  logic               m_valid,
   output logic               m_ready,
   input  logic [DN*BW-1:0]   cfg_bias,
   input  logic [4:0]         cfg_shift,
   input  logic               cfg_relu_en,
   input  logic [5:0]         cfg_width,
   output logic [DN*DW-1:0]   s_data,
   output logic               s_valid,
   input  logic               s_ready,
   output logic               s_eol,
   output logic               busy
`ifdef RELU_QUANT_SAT_CNT_EN
   ,
   output logic [15:0]        sat_cnt
`endif
);

   localparam logic signed [AW+1:0] QMAX = (AW+2)'((2 ** (DW-1)) - 1);
   localparam logic signed [AW+1:0] QMIN = ~QMAX;

   function automatic logic signed [AW:0] add_bias(input logic signed [AW-1:0] a,
                                                   input logic signed [BW-1:0] b);
      logic signed [AW:0] ae;
      logic signed [AW:0] be;
      ae = {a[AW-1], a};
      be = {{(AW+1-BW){b[BW-1]}}, b};
      return ae + be;
   endfunction

   function automatic logic signed [AW+1:0] round_relu(input logic signed [AW:0] s,
                                                       input logic [4:0] sh,
                                                       input logic relu);
      logic signed [AW+1:0] rnd;
      logic signed [AW+1:0] r;
      logic signed [AW+1:0] q;
      rnd = '0;
      if (sh != 5'd0) rnd = (AW+2)'(1) << (sh - 5'd1);
      r = {s[AW], s} + rnd;
      q = r >>> sh;
      if (relu && q < 0) q = '0;
      return q;
   endfunction

   function automatic logic [DW-1:0] saturate(input logic signed [AW+1:0] q);
      if (q > QMAX) return QMAX[DW-1:0];
      else if (q < QMIN) return QMIN[DW-1:0];
      else return q[DW-1:0];
   endfunction

   logic                  vld_p1_q, vld_p2_q;
   logic                  eol_p2_q, eol_p2_d;
   logic [DN*(AW+1)-1:0]  sum_p1_q, sum_p1_d;
   logic [DN*DW-1:0]      data_p2_q, data_p2_d;
   logic signed [AW+1:0]  q_lane [DN];
   logic [5:0]            cnt_q, cnt_d, width_q;
   logic [6:0]            width_eff;
   logic                  adv1, adv2;

   assign adv2    = !vld_p2_q || s_ready;
   assign adv1    = !vld_p1_q || adv2;
   assign m_ready = adv1;
   assign busy    = vld_p1_q || vld_p2_q;
   assign s_valid = vld_p2_q;
   assign s_data  = data_p2_q;
   assign s_eol   = vld_p2_q && eol_p2_q;

   // ---- stage 1: bias add
   always_comb begin
      sum_p1_d = '0;
      for (int i = 0; i < DN; i++)
         sum_p1_d[i*(AW+1) +: AW+1] = add_bias(m_data[i*AW +: AW], cfg_bias[i*BW +: BW]);
   end

   // ---- stage 2: round, ReLU, saturate; row position is fixed as the beat enters
   always_comb begin
      data_p2_d = '0;
      q_lane    = '{default: '0};
      for (int i = 0; i < DN; i++) begin
         q_lane[i] = round_relu(sum_p1_q[i*(AW+1) +: AW+1], cfg_shift, cfg_relu_en);
         data_p2_d[i*DW +: DW] = saturate(q_lane[i]);
      end
   end

   // A width of 0 means 64; the pixel index travels with the beat so eol is stall-proof.
   always_comb begin
      width_eff = {cfg_width == 6'd0, cfg_width};
      eol_p2_d  = ({1'b0, cnt_q} == (width_eff - 7'd1));
      cnt_d     = cnt_q;
      if (cfg_width != width_q) cnt_d = '0;
      else if (vld_p1_q && adv2) cnt_d = eol_p2_d ? 6'd0 : cnt_q + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         data_p2_q <= '0;
         eol_p2_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (adv1) vld_p1_q <= m_valid;
         if (adv2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
               data_p2_q <= data_p2_d;
               eol_p2_q  <= eol_p2_d;
            end
         end
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      width_q <= cfg_width;
      if (adv1 && m_valid) sum_p1_q <= sum_p1_d;
   end

`ifdef RELU_QUANT_SAT_CNT_EN
   logic        sat_p2_q, sat_p2_d;
   logic [15:0] sat_cnt_q;

   // ReLU has already clamped negatives to 0, so only true clipping lands here.
   always_comb begin
      sat_p2_d = 1'b0;
      for (int i = 0; i < DN; i++)
         sat_p2_d = sat_p2_d | (q_lane[i] > QMAX) | (q_lane[i] < QMIN);
   end

   always_ff @(posedge clk) begin
      if (adv2 && vld_p1_q) sat_p2_q <= sat_p2_d;
   end

   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else if (vld_p2_q && s_ready && sat_p2_q && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_relu_quant.sv
// Directed bench for relu_quant: vector table for the arithmetic, hand sequences for
// backpressure, row marker, mid-stream reset and (with RELU_QUANT_SAT_CNT_EN) the saturation counter.
module tb_relu_quant;
   localparam int DN = 6;
   localparam int DW = 8;
   localparam int AW = 24;
   localparam int BW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [DN*AW-1:0]  m_data;
   logic              m_valid;
   logic              m_ready;
   logic [DN*BW-1:0]  cfg_bias;
   logic [4:0]        cfg_shift;
   logic              cfg_relu_en;
   logic [5:0]        cfg_width;
   logic [DN*DW-1:0]  s_data;
   logic              s_valid;
   logic              s_ready;
   logic              s_eol;
   logic              busy;
`ifdef RELU_QUANT_SAT_CNT_EN
   logic [15:0]       sat_cnt;
`endif

   relu_quant dut (
      .clk(clk), .rst(rst),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en), .cfg_width(cfg_width),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_eol(s_eol), .busy(busy)
`ifdef RELU_QUANT_SAT_CNT_EN
      , .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] bias;
      logic [4:0]  sh;
      logic        relu;
      logic [23:0] val;
      logic [7:0]  exp;
   } vec_t;

   vec_t tbl [12];

   // Output transfers and hold-under-stall, observed on the falling edge.
   logic [DN*DW:0]   outq [$];
   logic             stall_prev = 1'b0;
   logic [DN*DW-1:0] prev_data  = '0;

   always @(negedge clk) begin
      if (stall_prev) begin
         chk("stall s_valid held", 64'(s_valid), 64'd1);
         chk("stall s_data held", 64'(s_data), 64'(prev_data));
      end
      stall_prev = s_valid && !s_ready && !rst;
      prev_data  = s_data;
      if (s_valid && s_ready && !rst) outq.push_back({s_eol, s_data});
   end

   task automatic beat(input logic [AW-1:0] v);
      m_data  = {DN{v}};
      m_valid = 1'b1;
      @(posedge clk); #1;
      m_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] lv;
      int sent;

      tbl[0]  = '{16'h0000, 5'd0,  1'b0, 24'h000005, 8'h05};
      tbl[1]  = '{16'h0000, 5'd4,  1'b0, 24'd24,     8'h02};
      tbl[2]  = '{16'h0000, 5'd4,  1'b0, 24'd23,     8'h01};
      tbl[3]  = '{16'h0008, 5'd4,  1'b0, 24'd8,      8'h01};
      tbl[4]  = '{16'h0000, 5'd0,  1'b0, 24'hFFFF9C, 8'h9C};
      tbl[5]  = '{16'h0000, 5'd0,  1'b0, 24'hFFFED4, 8'h80};
      tbl[6]  = '{16'h0000, 5'd0,  1'b0, 24'h00012C, 8'h7F};
      tbl[7]  = '{16'h0000, 5'd0,  1'b1, 24'hFFFF9C, 8'h00};
      tbl[8]  = '{16'h0000, 5'd0,  1'b1, 24'h00012C, 8'h7F};
      tbl[9]  = '{16'h0000, 5'd1,  1'b0, 24'hFFFFFD, 8'hFF};
      tbl[10] = '{16'h0000, 5'd23, 1'b0, 24'h7FFFFF, 8'h01};
      tbl[11] = '{16'hFFF0, 5'd0,  1'b0, 24'd10,     8'hFA};

      rst = 1'b1; m_valid = 1'b0; m_data = '0; cfg_bias = '0; cfg_shift = '0;
      cfg_relu_en = 1'b0; cfg_width = 6'd1; s_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset s_valid", 64'(s_valid), 64'd0);
      chk("reset s_data", 64'(s_data), 64'd0);
      chk("reset s_eol", 64'(s_eol), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset m_ready", 64'(m_ready), 64'd1);
      @(posedge clk); #1;

      // Single beats through an idle pipe, width 1 so every beat ends a row.
      for (int i = 0; i < 12; i++) begin
         cfg_bias    = {DN{tbl[i].bias}};
         cfg_shift   = tbl[i].sh;
         cfg_relu_en = tbl[i].relu;
         beat(tbl[i].val);
         @(negedge clk);
         chk($sformatf("vec%0d s_valid cycle1", i), 64'(s_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d s_valid cycle2", i), 64'(s_valid), 64'd1);
         chk($sformatf("vec%0d s_data", i), 64'(s_data), 64'({DN{tbl[i].exp}}));
         chk($sformatf("vec%0d s_eol", i), 64'(s_eol), 64'd1);
         @(posedge clk); #1;
      end

      // Distinct lane data and bias to pin down lane ordering.
      cfg_shift = '0; cfg_relu_en = 1'b0;
      for (int i = 0; i < DN; i++) begin
         m_data[i*AW +: AW]   = AW'(i + 1);
         cfg_bias[i*BW +: BW] = BW'(2 * i);
      end
      m_valid = 1'b1;
      @(posedge clk); #1 m_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("lanes s_data", 64'(s_data), 64'h100D0A070401);
      @(posedge clk); #1;
      cfg_bias = '0;

      // Backpressure: s_ready low in cycles 2..5 while beats 1..5 are offered.
      cfg_width = 6'd63;
      @(posedge clk); #1;
      outq.delete();
      sent = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         s_ready = !(cyc >= 2 && cyc <= 5);
         m_valid = (sent < 5);
         lv      = AW'(sent + 1);
         m_data  = {DN{lv}};
         @(negedge clk);
         if (cyc >= 2 && cyc <= 5) chk($sformatf("bp m_ready cycle%0d", cyc), 64'(m_ready), 64'd0);
         if (cyc == 6) chk("bp m_ready resumes", 64'(m_ready), 64'd1);
         if (m_valid && m_ready) sent++;
         @(posedge clk); #1;
      end
      m_valid = 1'b0; s_ready = 1'b1;
      chk("bp beats out", 64'(outq.size()), 64'd5);
      for (int k = 0; k < 5 && k < outq.size(); k++)
         chk($sformatf("bp order beat%0d", k + 1), 64'(outq[k][DN*DW-1:0]), 64'({DN{8'(k + 1)}}));

      // Row marker with width 2 over 6 back-to-back beats.
      cfg_width = 6'd2;
      repeat (2) @(posedge clk);
      #1 outq.delete();
      for (int k = 0; k < 6; k++) begin
         m_valid = 1'b1;
         lv      = AW'(k + 1);
         m_data  = {DN{lv}};
         @(posedge clk); #1;
      end
      m_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("row beats out", 64'(outq.size()), 64'd6);
      for (int k = 0; k < 6 && k < outq.size(); k++) begin
         chk($sformatf("row eol beat%0d", k + 1), 64'(outq[k][DN*DW]), 64'(k % 2 == 1));
         chk($sformatf("row data beat%0d", k + 1), 64'(outq[k][DN*DW-1:0]), 64'({DN{8'(k + 1)}}));
      end

      // Reset with two beats held in the pipe.
      s_ready = 1'b0;
      beat(24'd1);
      beat(24'd2);
      @(negedge clk);
      chk("pre-reset busy", 64'(busy), 64'd1);
      chk("pre-reset s_valid", 64'(s_valid), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post-reset s_valid", 64'(s_valid), 64'd0);
      chk("post-reset busy", 64'(busy), 64'd0);
      chk("post-reset m_ready", 64'(m_ready), 64'd1);
      @(posedge clk); #1;
      s_ready = 1'b1;
      outq.delete();
      beat(24'd7);
      repeat (3) @(posedge clk);
      #1;
      chk("post-reset beats out", 64'(outq.size()), 64'd1);
      if (outq.size() > 0)
         chk("post-reset beat eol/data", 64'(outq[0]), 64'({1'b0, {DN{8'h07}}}));

`ifdef RELU_QUANT_SAT_CNT_EN
      chk("sat_cnt after clean beat", 64'(sat_cnt), 64'd0);
      cfg_bias = '0; cfg_shift = '0; cfg_relu_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_valid = 1'b1;
         m_data  = {DN{24'd1}};
         if (k < 3) m_data[AW-1:0] = 24'h00012C;
         @(posedge clk); #1;
      end
      m_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("sat_cnt count", 64'(sat_cnt), 64'd3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("sat_cnt reset", 64'(sat_cnt), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
